// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN residual-add stage: default pixel width,
// saturation limits, frame-tracking state encoding and a saturating adder helper.
package cnn_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } frame_state_t;

    // Sign-extend both operands by one bit; a carry-out that disagrees with the
    // result sign means the true sum left the representable range.
    function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            return s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
        return s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/cnn_sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head: the oldest entry is always
// present on head, so a pop consumes it in the same cycle it is requested.
module cnn_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        head_d   = head_q;
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        // Prefetch the next head: from memory when one is queued behind it,
        // otherwise straight from the write port.
        if (do_pop) begin
            if (level_q == LW'(1)) begin
                if (do_push) head_d = wdata;
            end else begin
                head_d = mem_q[rd_ptr_q + AW'(1)];
            end
        end else if (do_push && empty) begin
            head_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = head_q;
    assign level = level_q;

endmodule

// File: rtl/cnn_residual_add_aligned.sv
// Residual add joining an early skip stream with a later main stream via a skip FIFO.
// Define CNN_RESADD_RELU_EN to fuse a ReLU after the saturating add.
module cnn_residual_add_aligned
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = cnn_pkg::DATA_WIDTH,
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int CHANNEL_NUM  = 256,
    parameter int FIFO_DEPTH   = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in_main,
    input  logic [DATA_WIDTH-1:0]         in_main,
    input  logic                          valid_in_skip,
    input  logic [DATA_WIDTH-1:0]         in_skip,
    output logic [DATA_WIDTH-1:0]         pxl_out,
    output logic                          valid_out,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_overflow,
    output logic                          err_underflow
);

    localparam int FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM;
    localparam int CW           = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    logic [DATA_WIDTH-1:0] fifo_head, partner, sat_val, res;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;

    frame_state_t          state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] pxl_q, pxl_d;
    logic                  valid_q, valid_d;
    logic                  fd_q, fd_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    // An empty FIFO with a skip sample already waiting is bypassed, never pushed.
    assign fifo_pop  = valid_in_main && !fifo_empty;
    assign fifo_push = valid_in_skip && !(valid_in_main && fifo_empty);

    cnn_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_skip_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (in_skip),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign partner = !fifo_empty   ? fifo_head :
                     valid_in_skip ? in_skip   : '0;

    generate
        if (DATA_WIDTH == cnn_pkg::DATA_WIDTH) begin : g_pkg_sat
            assign sat_val = sat_add(in_main, partner);
        end else begin : g_gen_sat
            logic [DATA_WIDTH:0] sum;
            assign sum     = {in_main[DATA_WIDTH-1], in_main} + {partner[DATA_WIDTH-1], partner};
            assign sat_val = (sum[DATA_WIDTH] == sum[DATA_WIDTH-1]) ? sum[DATA_WIDTH-1:0] :
                             sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                             : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endgenerate

`ifdef CNN_RESADD_RELU_EN
    assign res = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
    assign res = sat_val;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pxl_d   = pxl_q;
        valid_d = valid_in_main;
        fd_d    = 1'b0;
        ovf_d   = ovf_q || (valid_in_skip && !valid_in_main && fifo_full);
        unf_d   = unf_q || (valid_in_main && fifo_empty && !valid_in_skip);
        if (valid_in_main) begin
            pxl_d = res;
            // The counter holds outputs already emitted in this frame.
            if (cnt_q == CW'(FRAME_PIXELS - 1)) begin
                fd_d    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pxl_q   <= '0;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pxl_q   <= pxl_d;
            valid_q <= valid_d;
            fd_q    <= fd_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign pxl_out       = pxl_q;
    assign valid_out     = valid_q;
    assign frame_done    = fd_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule
